// File: rtl/tile_buffer_ring_pkg.sv
// Shared constants and helpers for the tile buffer ring: Sky130 macro geometry,
// error flag bit positions and a constant-foldable clog2.
package tile_buf_pkg;

  localparam int unsigned SRAM_WIDTH      = 32;
  localparam int unsigned SRAM_MASK_W     = 4;
  localparam int unsigned SRAM_MAX_ADDR_W = 8;
  localparam int unsigned SRAM_DEPTH      = 256;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UDF = 1;
  localparam int unsigned ERR_W   = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/tile_buffer_ring_if.sv
// Producer/consumer bus of the tile buffer ring; master drives requests,
// slave (the ring) returns status and read data.
interface tile_buffer_ring_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LANES      = 2,
  parameter int unsigned NUM_BANKS  = 2
);
  import tile_buf_pkg::*;

  localparam int unsigned DW = SRAM_WIDTH * LANES;
  localparam int unsigned MW = SRAM_MASK_W * LANES;
  localparam int unsigned BW = clog2(NUM_BANKS);

  logic                  flush;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DW-1:0]         wr_data;
  logic [MW-1:0]         wr_mask;
  logic                  wr_commit;
  logic                  wr_ready;
  logic [BW-1:0]         wr_bank;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DW-1:0]         rd_data;
  logic                  rd_valid;
  logic                  rd_release;
  logic                  rd_ready;
  logic [BW-1:0]         rd_bank;
  logic [BW:0]           fill_count;
  logic                  err_ovf;
  logic                  err_udf;

  modport master (
    output flush, wr_en, wr_addr, wr_data, wr_mask, wr_commit,
           rd_en, rd_addr, rd_release,
    input  wr_ready, wr_bank, rd_data, rd_valid, rd_ready, rd_bank,
           fill_count, err_ovf, err_udf
  );

  modport slave (
    input  flush, wr_en, wr_addr, wr_data, wr_mask, wr_commit,
           rd_en, rd_addr, rd_release,
    output wr_ready, wr_bank, rd_data, rd_valid, rd_ready, rd_bank,
           fill_count, err_ovf, err_udf
  );

endinterface

// File: rtl/sram_1rw1r_32_256_8_sky130.sv
// Behavioural stand-in for the Sky130 OpenRAM 1rw1r 32x256 macro with byte
// write mask; both ports register their read data on the rising clock.
module sram_1rw1r_32_256_8_sky130 (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [3:0]  wmask0,
  input  logic [7:0]  addr0,
  input  logic [31:0] din0,
  output logic [31:0] dout0,
  input  logic        clk1,
  input  logic        csb1,
  input  logic [7:0]  addr1,
  output logic [31:0] dout1
);

  logic [31:0] mem [256];

  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (wmask0[i]) begin
            mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
          end
        end
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!csb1) begin
      dout1 <= mem[addr1];
    end
  end

endmodule

// File: rtl/tile_buffer_ring_bank.sv
// One ring bank: LANES 32-bit macros side by side, port0 used write-only and
// port1 read-only.
module tile_buffer_bank
  import tile_buf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LANES      = 2
) (
  input  logic                            clk,
  input  logic                            wr_csb,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [SRAM_WIDTH*LANES-1:0]     wr_data,
  input  logic [SRAM_MASK_W*LANES-1:0]    wr_mask,
  input  logic                            rd_csb,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [SRAM_WIDTH*LANES-1:0]     rd_data
);

  localparam int unsigned DW = SRAM_WIDTH * LANES;

  logic [SRAM_MAX_ADDR_W-1:0] addr0;
  logic [SRAM_MAX_ADDR_W-1:0] addr1;
  logic [DW-1:0]              dout0_unused;

  always_comb begin
    addr0                   = '0;
    addr1                   = '0;
    addr0[ADDR_WIDTH-1:0]   = wr_addr;
    addr1[ADDR_WIDTH-1:0]   = rd_addr;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sram_1rw1r_32_256_8_sky130 u_sram (
      .clk0   (clk),
      .csb0   (wr_csb),
      .web0   (1'b0),
      .wmask0 (wr_mask[l*SRAM_MASK_W +: SRAM_MASK_W]),
      .addr0  (addr0),
      .din0   (wr_data[l*SRAM_WIDTH +: SRAM_WIDTH]),
      .dout0  (dout0_unused[l*SRAM_WIDTH +: SRAM_WIDTH]),
      .clk1   (clk),
      .csb1   (rd_csb),
      .addr1  (addr1),
      .dout1  (rd_data[l*SRAM_WIDTH +: SRAM_WIDTH])
    );
  end

endmodule

// File: rtl/tile_buffer_ring.sv
// N-bank tile buffer ring: producer fills banks in ring order and commits them,
// consumer drains in the same order and releases them.
module tile_buffer_ring
  import tile_buf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LANES      = 2,
  parameter int unsigned NUM_BANKS  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  tile_buffer_ring_if.slave  bus
);

  localparam int unsigned DW = SRAM_WIDTH * LANES;
  localparam int unsigned MW = SRAM_MASK_W * LANES;
  localparam int unsigned BW = clog2(NUM_BANKS);
  localparam logic [BW:0] COUNT_FULL = (BW+1)'(NUM_BANKS);

  logic [BW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]    rd_bank_q, rd_bank_d;
  logic [BW:0]      count_q, count_d;
  logic             rd_valid_q, rd_valid_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic wr_ready, rd_ready;
  logic wr_acc, commit_acc, rd_acc, release_acc;

  logic [NUM_BANKS-1:0]  bank_wr_csb;
  logic [NUM_BANKS-1:0]  bank_rd_csb;
  logic [ADDR_WIDTH-1:0] bank_wr_addr [NUM_BANKS];
  logic [ADDR_WIDTH-1:0] bank_rd_addr [NUM_BANKS];
  logic [DW-1:0]         bank_wr_data [NUM_BANKS];
  logic [MW-1:0]         bank_wr_mask [NUM_BANKS];
  logic [DW-1:0]         bank_rd_data [NUM_BANKS];

  // flush outranks every same-cycle request, so it gates all acceptances
  always_comb begin
    wr_ready    = (count_q != COUNT_FULL);
    rd_ready    = (count_q != '0);
    wr_acc      = bus.wr_en      && wr_ready && !bus.flush;
    commit_acc  = bus.wr_commit  && wr_ready && !bus.flush;
    rd_acc      = bus.rd_en      && rd_ready && !bus.flush;
    release_acc = bus.rd_release && rd_ready && !bus.flush;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_bank_d  = rd_bank_q;
    count_d    = count_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
    if (bus.flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      rd_bank_d = '0;
      count_d   = '0;
      err_d     = '0;
    end else begin
      if (commit_acc) begin
        wr_ptr_d = wr_ptr_q + BW'(1);
      end
      if (release_acc) begin
        rd_ptr_d = rd_ptr_q + BW'(1);
      end
      unique case ({commit_acc, release_acc})
        2'b10:   count_d = count_q + (BW+1)'(1);
        2'b01:   count_d = count_q - (BW+1)'(1);
        default: count_d = count_q;
      endcase
      // a read issued alongside a release still completes from the old bank
      if (rd_acc) begin
        rd_valid_d = 1'b1;
        rd_bank_d  = rd_ptr_q;
      end
      if ((bus.wr_en || bus.wr_commit) && !wr_ready) begin
        err_d[ERR_OVF] = 1'b1;
      end
      if ((bus.rd_en || bus.rd_release) && !rd_ready) begin
        err_d[ERR_UDF] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_bank_q  <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_bank_q  <= rd_bank_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // idle ports stay deselected with address/data held at zero
  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_wr_csb[b]  = 1'b1;
      bank_wr_addr[b] = '0;
      bank_wr_data[b] = '0;
      bank_wr_mask[b] = '0;
      bank_rd_csb[b]  = 1'b1;
      bank_rd_addr[b] = '0;
      if (wr_acc && (wr_ptr_q == BW'(b))) begin
        bank_wr_csb[b]  = 1'b0;
        bank_wr_addr[b] = bus.wr_addr;
        bank_wr_data[b] = bus.wr_data;
        bank_wr_mask[b] = bus.wr_mask;
      end
      if (rd_acc && (rd_ptr_q == BW'(b))) begin
        bank_rd_csb[b]  = 1'b0;
        bank_rd_addr[b] = bus.rd_addr;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    tile_buffer_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LANES      (LANES)
    ) u_bank (
      .clk     (clk),
      .wr_csb  (bank_wr_csb[g]),
      .wr_addr (bank_wr_addr[g]),
      .wr_data (bank_wr_data[g]),
      .wr_mask (bank_wr_mask[g]),
      .rd_csb  (bank_rd_csb[g]),
      .rd_addr (bank_rd_addr[g]),
      .rd_data (bank_rd_data[g])
    );
  end

  always_comb begin
    bus.wr_ready   = wr_ready;
    bus.rd_ready   = rd_ready;
    bus.wr_bank    = wr_ptr_q;
    bus.rd_bank    = rd_ptr_q;
    bus.fill_count = count_q;
    bus.rd_valid   = rd_valid_q;
    bus.rd_data    = bank_rd_data[rd_bank_q];
    bus.err_ovf    = err_q[ERR_OVF];
    bus.err_udf    = err_q[ERR_UDF];
  end

endmodule

// File: tb/tb_tile_buffer_ring.sv
// Scoreboard bench for tile_buffer_ring with four banks of two lanes.
module tb_tile_buffer_ring;

  localparam int unsigned AW = 8;
  localparam int unsigned LN = 2;
  localparam int unsigned NB = 4;

  typedef struct {
    logic [63:0] data;
    int unsigned due;
  } rd_exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int unsigned total;
  int unsigned bad;
  rd_exp_t     exp_q[$];

  tile_buffer_ring_if #(.ADDR_WIDTH(AW), .LANES(LN), .NUM_BANKS(NB)) bus ();

  tile_buffer_ring #(.ADDR_WIDTH(AW), .LANES(LN), .NUM_BANKS(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [63:0] pat(input logic [7:0] tag, input int unsigned a);
    return {tag, 24'(a), 32'hA5A5_0000 + 32'(a)};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_valid) begin
        check_eq("rd_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          rd_exp_t e;
          e = exp_q.pop_front();
          check_eq("rd_data", bus.rd_data, e.data);
          check_eq("rd_latency", 64'(cyc), 64'(e.due));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        check_eq("rd_valid", 64'(bus.rd_valid), 64'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int unsigned a, input logic [63:0] d, input logic [7:0] m);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    bus.wr_mask = m;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_read(input int unsigned a, input logic [63:0] want);
    rd_exp_t e;
    e.data = want;
    e.due  = cyc + 1;
    exp_q.push_back(e);
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(a);
    tick();
    bus.rd_en   = 1'b0;
  endtask

  task automatic do_commit();
    bus.wr_commit = 1'b1;
    tick();
    bus.wr_commit = 1'b0;
  endtask

  task automatic do_release();
    bus.rd_release = 1'b1;
    tick();
    bus.rd_release = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] masked;
    total = 0;
    bad   = 0;
    cyc   = 0;
    bus.flush = 0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0;
    bus.wr_commit = 0; bus.rd_en = 0; bus.rd_addr = '0; bus.rd_release = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    check_eq("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    check_eq("rst_rd_ready", 64'(bus.rd_ready), 64'd0);
    check_eq("rst_fill", 64'(bus.fill_count), 64'd0);
    check_eq("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check_eq("rst_wr_bank", 64'(bus.wr_bank), 64'd0);
    check_eq("rst_rd_bank", 64'(bus.rd_bank), 64'd0);
    check_eq("rst_err_ovf", 64'(bus.err_ovf), 64'd0);
    check_eq("rst_err_udf", 64'(bus.err_udf), 64'd0);

    // read from empty ring
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    tick();
    check_eq("udf_flag", 64'(bus.err_udf), 64'd1);
    check_eq("udf_fill", 64'(bus.fill_count), 64'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_eq("udf_flush_clear", 64'(bus.err_udf), 64'd0);

    // full bank 0 fill and back-to-back drain
    for (int unsigned a = 0; a < 256; a++) do_write(a, pat(8'h00, a), 8'hFF);
    do_commit();
    check_eq("b0_fill", 64'(bus.fill_count), 64'd1);
    check_eq("b0_wr_bank", 64'(bus.wr_bank), 64'd1);
    check_eq("b0_rd_bank", 64'(bus.rd_bank), 64'd0);
    check_eq("b0_rd_ready", 64'(bus.rd_ready), 64'd1);
    for (int unsigned a = 0; a < 256; a++) do_read(a, pat(8'h00, a));
    tick();
    tick();
    check_eq("b0_drained", 64'(exp_q.size()), 64'd0);

    // fill remaining banks to full
    for (int unsigned bk = 1; bk < NB; bk++) begin
      for (int unsigned a = 0; a < 8; a++) do_write(a, pat(8'(bk), a), 8'hFF);
      do_commit();
    end
    check_eq("full_fill", 64'(bus.fill_count), 64'd4);
    check_eq("full_wr_ready", 64'(bus.wr_ready), 64'd0);
    check_eq("full_wr_bank", 64'(bus.wr_bank), 64'd0);

    // overflow write and commit are dropped
    do_write(0, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    do_commit();
    check_eq("ovf_flag", 64'(bus.err_ovf), 64'd1);
    check_eq("ovf_fill", 64'(bus.fill_count), 64'd4);
    check_eq("ovf_wr_bank", 64'(bus.wr_bank), 64'd0);
    for (int unsigned a = 0; a < 4; a++) do_read(a, pat(8'h00, a));
    do_release();
    check_eq("rel_fill", 64'(bus.fill_count), 64'd3);
    check_eq("rel_rd_bank", 64'(bus.rd_bank), 64'd1);
    check_eq("rel_wr_ready", 64'(bus.wr_ready), 64'd1);

    // byte masks on the reclaimed bank 0
    do_write(3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_write(3, 64'h5566_7788_1122_3344, 8'b0011_0101);
    masked = 64'hFFFF_7788_FF22_FF44;
    do_commit();
    check_eq("mask_fill", 64'(bus.fill_count), 64'd4);

    for (int unsigned bk = 1; bk < NB; bk++) begin
      for (int unsigned a = 0; a < 8; a++) do_read(a, pat(8'(bk), a));
      do_release();
    end
    check_eq("drain_fill", 64'(bus.fill_count), 64'd1);
    check_eq("drain_rd_bank", 64'(bus.rd_bank), 64'd0);
    check_eq("drain_wr_bank", 64'(bus.wr_bank), 64'd1);

    // commit + release + read in one cycle
    for (int unsigned a = 0; a < 4; a++) do_write(a, pat(8'h44, a), 8'hFF);
    begin
      rd_exp_t e;
      e.data = masked;
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
    bus.rd_en = 1'b1; bus.rd_addr = AW'(3); bus.rd_release = 1'b1; bus.wr_commit = 1'b1;
    tick();
    bus.rd_en = 1'b0; bus.rd_release = 1'b0; bus.wr_commit = 1'b0;
    check_eq("cr_fill", 64'(bus.fill_count), 64'd1);
    check_eq("cr_wr_bank", 64'(bus.wr_bank), 64'd2);
    check_eq("cr_rd_bank", 64'(bus.rd_bank), 64'd1);
    for (int unsigned a = 0; a < 4; a++) do_read(a, pat(8'h44, a));
    tick();
    tick();
    check_eq("cr_drained", 64'(exp_q.size()), 64'd0);

    // flush with a same-cycle read
    check_eq("pre_flush_ovf", 64'(bus.err_ovf), 64'd1);
    bus.rd_en = 1'b1; bus.rd_addr = '0; bus.flush = 1'b1;
    tick();
    bus.rd_en = 1'b0; bus.flush = 1'b0;
    check_eq("flush_rd_valid", 64'(bus.rd_valid), 64'd0);
    check_eq("flush_fill", 64'(bus.fill_count), 64'd0);
    check_eq("flush_wr_bank", 64'(bus.wr_bank), 64'd0);
    check_eq("flush_rd_bank", 64'(bus.rd_bank), 64'd0);
    check_eq("flush_err_ovf", 64'(bus.err_ovf), 64'd0);
    check_eq("flush_err_udf", 64'(bus.err_udf), 64'd0);
    check_eq("flush_wr_ready", 64'(bus.wr_ready), 64'd1);
    tick();
    tick();

    // asynchronous reset in the middle of a fill with a read in flight
    do_write(0, pat(8'h77, 0), 8'hFF);
    do_commit();
    do_write(0, pat(8'h78, 0), 8'hFF);
    bus.rd_en = 1'b1; bus.rd_addr = '0; bus.wr_en = 1'b1;
    @(posedge clk);
    #2;
    check_eq("pre_rst_rd_valid", 64'(bus.rd_valid), 64'd1);
    check_eq("pre_rst_wr_bank", 64'(bus.wr_bank), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check_eq("arst_fill", 64'(bus.fill_count), 64'd0);
    check_eq("arst_wr_ready", 64'(bus.wr_ready), 64'd1);
    check_eq("arst_rd_ready", 64'(bus.rd_ready), 64'd0);
    check_eq("arst_wr_bank", 64'(bus.wr_bank), 64'd0);
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check_eq("post_rst_fill", 64'(bus.fill_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
